// File: rtl/active_list_retire.sv
// -----------------------------------------------------------------------------
// active_list_retire
//
// In-order completion and retire tracker that sits just after writeback.
// Each dispatched instruction gets one active-list entry at the tail. Entries
// are marked done by four writeback lanes and can be flagged by a
// load-ordering violation. Up to two entries retire per cycle from the head,
// in program order. When an excepting or violating entry reaches the head,
// a one-cycle flush pulse is raised that carries its PC, and the list is
// emptied.
//
// Optional build macro: ACTIVE_LIST_STATS_EN
//   defined   -> stat_commits_o / stat_recovers_o are live wrapping counters
//   undefined -> both ports are tied to zero and no counter flops exist
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   dispatch_valid_i dispatch request
//   dispatch_pc_i    PC of the dispatching instruction
//   dispatch_ready_o an entry is free and the tracker is running
//   dispatch_idx_o   index given to the current dispatch (the tail)
//   wb_valid_i       per-lane writeback valid, lanes 0..3
//   wb_pkt_i         lane n = bits [n*(AL_LOG+WB_FLAGS) +: AL_LOG+WB_FLAGS],
//                    laid out as {index, flags}
//   ld_viol_i        {valid, index} of a load that violated ordering
//   commit_valid_o   registered; bit0 = oldest retired, bit1 = second oldest
//   commit_pc0_o     PC retired in slot 0
//   commit_pc1_o     PC retired in slot 1
//   recover_o        registered one-cycle flush pulse
//   recover_pc_o     PC of the excepting or violating instruction
//   count_o          number of occupied entries
//   stat_commits_o   retired-instruction counter
//   stat_recovers_o  recovery counter
//
// State table
//   state      | meaning
//   ST_RUN     | normal dispatch, writeback and retire
//   ST_RECOVER | one flush cycle: list cleared, all inputs ignored
// -----------------------------------------------------------------------------
module active_list_retire #(
    parameter int DEPTH    = 32,
    parameter int AL_LOG   = 5,
    parameter int WB_FLAGS = 4,
    parameter int PC_W     = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              dispatch_valid_i,
    input  logic [PC_W-1:0]                   dispatch_pc_i,
    output logic                              dispatch_ready_o,
    output logic [AL_LOG-1:0]                 dispatch_idx_o,
    input  logic [3:0]                        wb_valid_i,
    input  logic [4*(AL_LOG+WB_FLAGS)-1:0]    wb_pkt_i,
    input  logic [AL_LOG:0]                   ld_viol_i,
    output logic [1:0]                        commit_valid_o,
    output logic [PC_W-1:0]                   commit_pc0_o,
    output logic [PC_W-1:0]                   commit_pc1_o,
    output logic                              recover_o,
    output logic [PC_W-1:0]                   recover_pc_o,
    output logic [AL_LOG:0]                   count_o,
    output logic [31:0]                       stat_commits_o,
    output logic [15:0]                       stat_recovers_o
);

    localparam int LANES = 4;
    localparam int PKT_W = AL_LOG + WB_FLAGS;

    typedef enum logic {
        ST_RUN,
        ST_RECOVER
    } state_t;

    state_t state_q, state_d;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AL_LOG:0]       head, tail;
    logic [AL_LOG-1:0]     head_idx, head1_idx, tail_idx;
    logic                  full;

    logic [DEPTH-1:0]      ent_valid;
    logic [DEPTH-1:0]      ent_done;
    logic [DEPTH-1:0]      ent_viol;
    logic [WB_FLAGS-1:0]   ent_flags [DEPTH];
    logic [PC_W-1:0]       ent_pc    [DEPTH];

    logic [AL_LOG-1:0]     wb_idx [LANES];
    logic [WB_FLAGS-1:0]   wb_flg [LANES];
    logic [AL_LOG-1:0]     viol_idx;
    logic                  viol_valid;

    logic                  dispatch_fire;
    logic                  bad0, bad1, ok0, ok1;
    logic                  retire0, retire1, recover_hit;
    logic [1:0]            retire_cnt;

    assign head_idx  = head[AL_LOG-1:0];
    assign head1_idx = head_idx + AL_LOG'(1);
    assign tail_idx  = tail[AL_LOG-1:0];
    assign full      = (head_idx == tail_idx) && (head[AL_LOG] != tail[AL_LOG]);

    assign count_o          = tail - head;
    assign dispatch_idx_o   = tail_idx;
    // Gated with reset so the port reads 0 while reset is held.
    assign dispatch_ready_o = reset && (state_q == ST_RUN) && !full;
    assign dispatch_fire    = dispatch_valid_i && dispatch_ready_o;

    assign viol_valid = ld_viol_i[AL_LOG];
    assign viol_idx   = ld_viol_i[AL_LOG-1:0];

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            wb_flg[l] = wb_pkt_i[l*PKT_W +: WB_FLAGS];
            wb_idx[l] = wb_pkt_i[l*PKT_W + WB_FLAGS +: AL_LOG];
        end
    end

    // Only flag bit 0 is interpreted; the rest are kept for debug visibility.
    logic unused_flag_bits;
    always_comb begin
        unused_flag_bits = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            unused_flag_bits = unused_flag_bits ^ (^ent_flags[i][WB_FLAGS-1:1]);
        end
    end

    // Retire eligibility looks only at registered entry state, so a
    // writeback landing this cycle is seen one cycle later.
    assign ok0  = ent_valid[head_idx]  && ent_done[head_idx];
    assign ok1  = ent_valid[head1_idx] && ent_done[head1_idx];
    assign bad0 = ent_flags[head_idx][0]  || ent_viol[head_idx];
    assign bad1 = ent_flags[head1_idx][0] || ent_viol[head1_idx];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        retire0     = 1'b0;
        retire1     = 1'b0;
        recover_hit = 1'b0;
        case (state_q)
            ST_RUN: begin
                retire0     = ok0 && !bad0;
                retire1     = retire0 && ok1 && !bad1;
                recover_hit = ok0 && bad0;
                if (recover_hit) begin
                    state_d = ST_RECOVER;
                end
            end
            ST_RECOVER: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign retire_cnt = {1'b0, retire0} + {1'b0, retire1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
        end else if (state_q == ST_RECOVER) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head + {{(AL_LOG-1){1'b0}}, retire_cnt};
            tail <= tail + {{AL_LOG{1'b0}}, dispatch_fire};
        end
    end

    // Entry storage. Later assignments win, so retire invalidation overrides
    // any writeback that hits an entry in the cycle it retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_valid <= '0;
            ent_done  <= '0;
            ent_viol  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                ent_flags[i] <= '0;
                ent_pc[i]    <= '0;
            end
        end else if (state_q == ST_RECOVER) begin
            ent_valid <= '0;
            ent_done  <= '0;
            ent_viol  <= '0;
        end else begin
            if (dispatch_fire) begin
                ent_valid[tail_idx] <= 1'b1;
                ent_done[tail_idx]  <= 1'b0;
                ent_viol[tail_idx]  <= 1'b0;
                ent_flags[tail_idx] <= '0;
                ent_pc[tail_idx]    <= dispatch_pc_i;
            end
            // Ascending lane order: the highest-numbered lane's flags win.
            for (int l = 0; l < LANES; l++) begin
                if (wb_valid_i[l] && ent_valid[wb_idx[l]]) begin
                    ent_done[wb_idx[l]]  <= 1'b1;
                    ent_flags[wb_idx[l]] <= wb_flg[l];
                end
            end
            if (viol_valid && ent_valid[viol_idx]) begin
                ent_viol[viol_idx] <= 1'b1;
            end
            if (retire0) begin
                ent_valid[head_idx] <= 1'b0;
            end
            if (retire1) begin
                ent_valid[head1_idx] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            commit_valid_o <= '0;
            commit_pc0_o   <= '0;
            commit_pc1_o   <= '0;
            recover_o      <= 1'b0;
            recover_pc_o   <= '0;
        end else begin
            commit_valid_o <= {retire1, retire0};
            commit_pc0_o   <= retire0 ? ent_pc[head_idx]  : '0;
            commit_pc1_o   <= retire1 ? ent_pc[head1_idx] : '0;
            recover_o      <= recover_hit;
            recover_pc_o   <= recover_hit ? ent_pc[head_idx] : '0;
        end
    end

`ifdef ACTIVE_LIST_STATS_EN
    logic [31:0] stat_commits;
    logic [15:0] stat_recovers;

    // Counts follow the registered pulses, so they trail them by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_commits  <= '0;
            stat_recovers <= '0;
        end else begin
            stat_commits  <= stat_commits + 32'(commit_valid_o[0]) + 32'(commit_valid_o[1]);
            stat_recovers <= stat_recovers + 16'(recover_o);
        end
    end

    assign stat_commits_o  = stat_commits;
    assign stat_recovers_o = stat_recovers;
`else
    assign stat_commits_o  = '0;
    assign stat_recovers_o = '0;
`endif

endmodule

// File: tb/tb_active_list_retire.sv
module tb_active_list_retire;

    logic        clk;
    logic        reset;
    logic        dispatch_valid_i;
    logic [31:0] dispatch_pc_i;
    logic        dispatch_ready_o;
    logic [4:0]  dispatch_idx_o;
    logic [3:0]  wb_valid_i;
    logic [35:0] wb_pkt_i;
    logic [5:0]  ld_viol_i;
    logic [1:0]  commit_valid_o;
    logic [31:0] commit_pc0_o;
    logic [31:0] commit_pc1_o;
    logic        recover_o;
    logic [31:0] recover_pc_o;
    logic [5:0]  count_o;
    logic [31:0] stat_commits_o;
    logic [15:0] stat_recovers_o;

    int tests_run = 0;
    int tests_failed = 0;

    active_list_retire dut (
        .clk              (clk),
        .reset            (reset),
        .dispatch_valid_i (dispatch_valid_i),
        .dispatch_pc_i    (dispatch_pc_i),
        .dispatch_ready_o (dispatch_ready_o),
        .dispatch_idx_o   (dispatch_idx_o),
        .wb_valid_i       (wb_valid_i),
        .wb_pkt_i         (wb_pkt_i),
        .ld_viol_i        (ld_viol_i),
        .commit_valid_o   (commit_valid_o),
        .commit_pc0_o     (commit_pc0_o),
        .commit_pc1_o     (commit_pc1_o),
        .recover_o        (recover_o),
        .recover_pc_o     (recover_pc_o),
        .count_o          (count_o),
        .stat_commits_o   (stat_commits_o),
        .stat_recovers_o  (stat_recovers_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [31:0] pc;
        logic [3:0]  wbv;
        logic [35:0] wbp;
        logic [5:0]  lv;
        logic [1:0]  e_cv;
        logic [31:0] e_pc0;
        logic [31:0] e_pc1;
        logic        e_rec;
        logic [31:0] e_rpc;
        logic [5:0]  e_cnt;
        logic        e_rdy;
        logic [4:0]  e_idx;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [35:0] ln(int n, logic [4:0] idx, logic [3:0] fl);
        logic [35:0] r;
        r = '0;
        r[n*9 +: 9] = {idx, fl};
        return r;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        dispatch_valid_i = 1'b0;
        dispatch_pc_i    = '0;
        wb_valid_i       = '0;
        wb_pkt_i         = '0;
        ld_viol_i        = '0;
    endtask

    task automatic dispatch_one(logic [31:0] pc);
        dispatch_valid_i = 1'b1;
        dispatch_pc_i    = pc;
        step();
        dispatch_valid_i = 1'b0;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;

        //        dv  pc        wbv      wbp                                       lv     cv     pc0       pc1       rec  rpc       cnt rdy idx
        vecs.push_back('{1, 32'h100, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   1, 1, 1});
        vecs.push_back('{1, 32'h104, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   2, 1, 2});
        vecs.push_back('{1, 32'h108, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   3, 1, 3});
        vecs.push_back('{0, 32'h0,   4'b1110, ln(3,2,0) | ln(2,1,0) | ln(1,0,0),       6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   3, 1, 3});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b11, 32'h100, 32'h104, 0, 32'h0,   1, 1, 3});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b01, 32'h108, 32'h0,   0, 32'h0,   0, 1, 3});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   0, 1, 3});
        vecs.push_back('{1, 32'h200, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   1, 1, 4});
        vecs.push_back('{1, 32'h204, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   2, 1, 5});
        vecs.push_back('{0, 32'h0,   4'b0011, ln(0,3,1) | ln(1,4,0),                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   2, 1, 5});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   1, 32'h200, 2, 0, 5});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   0, 1, 0});
        vecs.push_back('{0, 32'h0,   4'b0001, ln(0,7,0),                               6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   0, 1, 0});
        vecs.push_back('{1, 32'h300, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   1, 1, 1});
        vecs.push_back('{0, 32'h0,   4'b0101, ln(0,0,1) | ln(2,0,0),                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   1, 1, 1});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b01, 32'h300, 32'h0,   0, 32'h0,   0, 1, 1});
        vecs.push_back('{1, 32'h304, 4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   1, 1, 2});
        vecs.push_back('{0, 32'h0,   4'b1010, ln(1,1,0) | ln(3,1,1),                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   1, 1, 2});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   1, 32'h304, 1, 0, 2});
        vecs.push_back('{0, 32'h0,   4'b0000, 36'h0,                                   6'h0, 2'b00, 32'h0,   32'h0,   0, 32'h0,   0, 1, 0});

        // Reset state
        #12;
        check("rst_ready",  64'(dispatch_ready_o), 64'd0);
        check("rst_count",  64'(count_o), 64'd0);
        check("rst_commit", 64'(commit_valid_o), 64'd0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", 64'(dispatch_ready_o), 64'd1);
        check("post_rst_idx",   64'(dispatch_idx_o), 64'd0);

        // Table-driven vectors
        for (int v = 0; v < vecs.size(); v++) begin
            dispatch_valid_i = vecs[v].dv;
            dispatch_pc_i    = vecs[v].pc;
            wb_valid_i       = vecs[v].wbv;
            wb_pkt_i         = vecs[v].wbp;
            ld_viol_i        = vecs[v].lv;
            step();
            check($sformatf("v%0d_commit_valid", v), 64'(commit_valid_o), 64'(vecs[v].e_cv));
            if (vecs[v].e_cv[0]) check($sformatf("v%0d_pc0", v), 64'(commit_pc0_o), 64'(vecs[v].e_pc0));
            if (vecs[v].e_cv[1]) check($sformatf("v%0d_pc1", v), 64'(commit_pc1_o), 64'(vecs[v].e_pc1));
            check($sformatf("v%0d_recover", v), 64'(recover_o), 64'(vecs[v].e_rec));
            if (vecs[v].e_rec) check($sformatf("v%0d_recover_pc", v), 64'(recover_pc_o), 64'(vecs[v].e_rpc));
            check($sformatf("v%0d_count", v), 64'(count_o), 64'(vecs[v].e_cnt));
            check($sformatf("v%0d_ready", v), 64'(dispatch_ready_o), 64'(vecs[v].e_rdy));
            check($sformatf("v%0d_idx", v), 64'(dispatch_idx_o), 64'(vecs[v].e_idx));
        end
        idle_inputs();

        // Fill all 32 entries, then a pending 33rd dispatch
        for (int i = 0; i < 32; i++) dispatch_one(32'h1000 + 32'(4*i));
        check("full_ready", 64'(dispatch_ready_o), 64'd0);
        check("full_count", 64'(count_o), 64'd32);
        dispatch_valid_i = 1'b1;
        dispatch_pc_i    = 32'h2000;
        step();
        check("pending_count", 64'(count_o), 64'd32);
        check("pending_idx",   64'(dispatch_idx_o), 64'd0);
        wb_valid_i = 4'b0001;
        wb_pkt_i   = ln(0, 0, 0);
        step();
        check("full_wb_count", 64'(count_o), 64'd32);
        wb_valid_i = '0;
        wb_pkt_i   = '0;
        step();
        check("full_retire_cv",  64'(commit_valid_o), 64'b01);
        check("full_retire_pc0", 64'(commit_pc0_o), 64'h1000);
        check("full_retire_cnt", 64'(count_o), 64'd31);
        check("full_retire_rdy", 64'(dispatch_ready_o), 64'd1);
        check("full_retire_idx", 64'(dispatch_idx_o), 64'd0);
        step();
        check("pending_accept_cnt", 64'(count_o), 64'd32);
        check("pending_accept_idx", 64'(dispatch_idx_o), 64'd1);
        dispatch_valid_i = 1'b0;

        // Drain to head=31, then retire 31 and 0 together across the wrap
        for (int i = 1; i <= 30; i++) begin
            wb_valid_i = 4'b0001;
            wb_pkt_i   = ln(0, 5'(i), 0);
            step();
        end
        idle_inputs();
        step(); step(); step();
        check("drain_count", 64'(count_o), 64'd2);
        wb_valid_i = 4'b0011;
        wb_pkt_i   = ln(0, 31, 0) | ln(1, 0, 0);
        step();
        idle_inputs();
        step();
        check("wrap_cv",    64'(commit_valid_o), 64'b11);
        check("wrap_pc0",   64'(commit_pc0_o), 64'h107C);
        check("wrap_pc1",   64'(commit_pc1_o), 64'h2000);
        check("wrap_count", 64'(count_o), 64'd0);
        check("wrap_idx",   64'(dispatch_idx_o), 64'd1);

        // Asynchronous reset with 5 entries pending
        for (int i = 0; i < 5; i++) dispatch_one(32'h600 + 32'(4*i));
        check("pre_rst_count", 64'(count_o), 64'd5);
        reset = 1'b0;
        #1;
        check("async_rst_count", 64'(count_o), 64'd0);
        check("async_rst_idx",   64'(dispatch_idx_o), 64'd0);
        check("async_rst_ready", 64'(dispatch_ready_o), 64'd0);
        check("async_rst_cv",    64'(commit_valid_o), 64'd0);
        check("async_rst_rec",   64'(recover_o), 64'd0);
        check("async_rst_stats", 64'({stat_commits_o, 16'(stat_recovers_o)}), 64'd0);
        @(posedge clk); @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("rel_count", 64'(count_o), 64'd0);
        check("rel_idx",   64'(dispatch_idx_o), 64'd0);
        check("rel_ready", 64'(dispatch_ready_o), 64'd1);
        @(posedge clk);
        #1;

        // Load violation on the second entry: first retires alone, then flush
        dispatch_one(32'h400);
        dispatch_one(32'h404);
        dispatch_one(32'h408);
        ld_viol_i = {1'b1, 5'd1};
        step();
        ld_viol_i  = '0;
        wb_valid_i = 4'b0111;
        wb_pkt_i   = ln(0, 0, 0) | ln(1, 1, 0) | ln(2, 2, 0);
        step();
        idle_inputs();
        step();
        check("viol_cv",    64'(commit_valid_o), 64'b01);
        check("viol_pc0",   64'(commit_pc0_o), 64'h400);
        check("viol_rec0",  64'(recover_o), 64'd0);
        check("viol_count", 64'(count_o), 64'd2);
        step();
        check("viol_rec",    64'(recover_o), 64'd1);
        check("viol_rec_pc", 64'(recover_pc_o), 64'h404);
        check("viol_rec_cv", 64'(commit_valid_o), 64'd0);
        step();
        check("viol_rec_end",  64'(recover_o), 64'd0);
        check("viol_end_cnt",  64'(count_o), 64'd0);
        check("viol_end_rdy",  64'(dispatch_ready_o), 64'd1);
`ifdef ACTIVE_LIST_STATS_EN
        check("stat_commits",  64'(stat_commits_o), 64'd1);
        check("stat_recovers", 64'(stat_recovers_o), 64'd1);
`else
        check("stat_commits",  64'(stat_commits_o), 64'd0);
        check("stat_recovers", 64'(stat_recovers_o), 64'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/active_list_retire.md
Name: active_list_retire

Overview:
- In-order completion and retire tracker that sits directly downstream of writeback.
- Allocates one active-list entry per dispatched instruction.
- Consumes the four writeback control packets (active-list index plus writeback flags) and the load-violation packet, marks entries complete, and retires up to two entries per cycle in program order.
- When an excepting or violating instruction reaches the head, it pulses a flush request with that instruction's PC.

Parameters:
- DEPTH, 32: number of active-list entries; must be a power of 2.
- AL_LOG, 5: log2(DEPTH).
- WB_FLAGS, 4: writeback flag width. Bit0 = exception; other bits are stored but not interpreted.
- PC_W, 32: PC width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dispatch_valid_i  in  1  dispatch request.
- dispatch_pc_i  in  PC_W  PC of the dispatching instruction.
- dispatch_ready_o  out  1  entry available; a dispatch is accepted when valid & ready.
- dispatch_idx_o  out  AL_LOG  index allocated to the current dispatch (the tail).
- wb_valid_i  in  4  per-lane writeback valid; lanes 0..3.
- wb_pkt_i  in  4*(AL_LOG+WB_FLAGS)  lane n occupies bits [n*(AL_LOG+WB_FLAGS) +: AL_LOG+WB_FLAGS] = {index, flags}.
- ld_viol_i  in  AL_LOG+1  {valid, index} of a load that violated ordering.
- commit_valid_o  out  2  registered; bit0 = oldest retired this cycle, bit1 = second oldest.
- commit_pc0_o  out  PC_W  PC retired in slot 0.
- commit_pc1_o  out  PC_W  PC retired in slot 1.
- recover_o  out  1  registered one-cycle flush pulse.
- recover_pc_o  out  PC_W  PC of the excepting or violating instruction.
- count_o  out  AL_LOG+1  number of occupied entries.
- stat_commits_o  out  32  retired-instruction counter (see Optional Feature).
- stat_recovers_o  out  16  recovery counter (see Optional Feature).

Behaviour:
- Storage and pointers
  - Per entry: valid, done, flags, viol, pc.
  - head and tail pointers are AL_LOG+1 bits; the MSB is the wrap bit.
  - full when the low bits are equal and the wrap bits differ; empty when the pointers are fully equal.
  - count_o = tail - head, computed modulo 2^(AL_LOG+1).
- Reset (reset=0, asynchronous)
  - head = tail = 0; all valid/done/viol cleared; state = RUN.
  - All outputs 0 except dispatch_ready_o = 1 once reset is released.
- Dispatch
  - dispatch_ready_o = (state==RUN) & ~full.
  - On accept: entry[tail] written with {valid=1, done=0, viol=0, pc}, and tail increments.
  - dispatch_idx_o = tail[AL_LOG-1:0], combinational.
- Writeback
  - For each lane with wb_valid_i=1 whose indexed entry is valid: done=1 and flags stored at the clock edge.
  - Lanes targeting an invalid entry are ignored.
  - Two lanes naming the same index: the highest-numbered lane's flags win.
  - An entry marked done is retire-eligible no earlier than the following cycle.
- Load violation
  - When ld_viol_i[AL_LOG]=1 and the indexed entry is valid, set viol=1. This may occur before or after that entry is done.
- Retire (state RUN, evaluated on the registered entry state)
  - Define bad(e) = flags[0] | viol.
  - slot0 retires if entry[head] is valid & done & ~bad.
  - slot1 retires if slot0 retires and entry[head+1] is valid & done & ~bad.
  - head advances by the number retired; retired entries are invalidated.
  - commit_valid_o and commit_pc*_o are registered, so retirement is visible the cycle after the eligibility edge.
  - Retire across the wrap point (head = DEPTH-1, head+1 = 0) is legal.
- Recovery
  - If entry[head] is valid & done & bad: nothing retires that cycle.
  - recover_o=1 and recover_pc_o = entry[head].pc on the next edge; state -> RECOVER.
  - RECOVER lasts exactly one cycle: all valid bits cleared, head = tail = 0, writebacks and violations ignored, dispatch_ready_o=0. Then state -> RUN.
  - If the second-oldest entry is bad while the head is good, only slot0 retires; the bad entry becomes head and triggers recovery next cycle.
- Simultaneous events
  - Dispatch and retire in the same cycle are both applied.
  - A writeback to the head in the same cycle as a retire evaluation affects the following cycle only.
  - A dispatch to a full list is not accepted; dispatch_valid_i stays pending.
- Outputs not pulsing hold 0: commit_valid_o when nothing retires, recover_o outside recovery.

Optional Feature:
- Macro ACTIVE_LIST_STATS_EN.
- Defined:
  - stat_commits_o increments by popcount(commit_valid_o) each cycle.
  - stat_recovers_o increments on each recover_o pulse.
  - Both wrap on overflow, reset to 0, and are not cleared by recovery.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Dispatch PCs 0x100,0x104,0x108; writeback idx 2,1,0 on lanes 3,2,1 in one cycle -> next cycle commit_valid_o=2'b11 (PCs 0x100,0x104); following cycle commit_valid_o=2'b01 (PC 0x108); count_o=0.
- 32 dispatches with no writebacks -> dispatch_ready_o=0, count_o=32; a 33rd request stays pending; writeback idx 0 -> idx 0 retires, and the pending dispatch is accepted with dispatch_idx_o=0.
- head=31 with entries 31 and 0 done -> both retire in one cycle; head=1.
- Dispatch 0x200,0x204; writeback idx0 with flags=4'b0001, idx1 clean -> recover_o=1 for one cycle with recover_pc_o=0x200, no commit, then count_o=0 and dispatch_ready_o=1 after the one-cycle RECOVER state.
- Dispatch three entries; ld_viol_i={1,idx1}; writeback all -> idx0 retires alone, next cycle recover_o with PC of idx1; with ACTIVE_LIST_STATS_EN defined, stat_commits_o=1 and stat_recovers_o=1.
- Assert reset low mid-stream with 5 entries pending -> all outputs 0 immediately; after release count_o=0 and dispatch_idx_o=0.
